// File: rtl/meas_pkg.sv
// meas_pkg: definitions shared by `meas` and `id_vote`.
// Holds the primitive-ID width, the vote FSM state type and the width helper
// for the unstable-bit count. Keeping the ID width here prevents the
// producer and the voter from drifting apart.
package meas_pkg;

  localparam int unsigned C_OIDWIDTH = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } vote_state_e;

  // Bits needed to hold a popcount of a w-bit vector (0..w inclusive).
  function automatic int unsigned ucnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/id_vote_if.sv
// id_vote_if: measurement handshake and voted-result bundle of id_vote.
//   I_start          start a vote (one-cycle pulse)
//   I_prim_id/vld    measurement from `meas`
//   O_meas_req       request for the next measurement
//   O_busy           vote in progress
//   O_id_vld         new result on O_id / O_unstable_mask / O_unstable_cnt
//   O_err            sticky measurement timeout
// master: the side that starts votes and supplies measurements.
// slave:  the voter itself.
interface id_vote_if #(
  parameter int unsigned C_OIDWIDTH = meas_pkg::C_OIDWIDTH
);
  import meas_pkg::*;

  localparam int unsigned C_UCNTW = ucnt_width(C_OIDWIDTH);

  logic                  I_start;
  logic [C_OIDWIDTH-1:0] I_prim_id;
  logic                  I_prim_vld;
  logic                  O_meas_req;
  logic                  O_busy;
  logic                  O_id_vld;
  logic [C_OIDWIDTH-1:0] O_id;
  logic [C_OIDWIDTH-1:0] O_unstable_mask;
  logic [C_UCNTW-1:0]    O_unstable_cnt;
  logic                  O_err;

  modport master (
    output I_start, I_prim_id, I_prim_vld,
    input  O_meas_req, O_busy, O_id_vld, O_id, O_unstable_mask,
           O_unstable_cnt, O_err
  );

  modport slave (
    input  I_start, I_prim_id, I_prim_vld,
    output O_meas_req, O_busy, O_id_vld, O_id, O_unstable_mask,
           O_unstable_cnt, O_err
  );

endinterface

// File: rtl/id_vote_bitcnt.sv
// id_vote_bitcnt: one-count for a single ID bit across a vote, plus the
// majority and stability decisions for that bit.
//   I_sclk, I_rst_n  clock, synchronous active-low reset
//   I_clr            clear the count (start of a vote)
//   I_inc            add one (measurement accepted with this bit set)
//   O_maj            count is a strict majority of C_VOTENUM
//   O_unstable       count is not within C_MARGIN of either extreme
module id_vote_bitcnt #(
  parameter int unsigned C_VOTENUM  = 15,
  parameter int unsigned C_CNTWIDTH = 4,
  parameter int unsigned C_MARGIN   = 2
) (
  input  logic I_sclk,
  input  logic I_rst_n,
  input  logic I_clr,
  input  logic I_inc,
  output logic O_maj,
  output logic O_unstable
);

  localparam logic [C_CNTWIDTH-1:0] C_HALF = C_CNTWIDTH'(C_VOTENUM / 2);
  localparam logic [C_CNTWIDTH-1:0] C_LO   = C_CNTWIDTH'(C_MARGIN);
  localparam logic [C_CNTWIDTH-1:0] C_HI   = C_CNTWIDTH'(C_VOTENUM - C_MARGIN);

  logic [C_CNTWIDTH-1:0] cnt_q;

  // At most C_VOTENUM increments per vote and the counter is wide enough
  // for that, so no wrap guard is needed.
  always_ff @(posedge I_sclk) begin
    if (!I_rst_n) begin
      cnt_q <= '0;
    end else if (I_clr) begin
      cnt_q <= '0;
    end else if (I_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign O_maj      = (cnt_q > C_HALF);
  assign O_unstable = !((cnt_q <= C_LO) || (cnt_q >= C_HI));

endmodule

// File: rtl/id_vote.sv
// id_vote: majority-vote stabiliser for primitive IDs from `meas`.
// Requests C_VOTENUM measurements, counts ones per bit, then publishes the
// voted ID, a per-bit instability mask and its popcount.
//   I_sclk   system clock
//   I_rst_n  synchronous active-low reset
//   bus      id_vote_if slave: start/measurement inputs, registered results
module id_vote
  import meas_pkg::*;
#(
  parameter int unsigned C_OIDWIDTH = meas_pkg::C_OIDWIDTH,
  parameter int unsigned C_VOTENUM  = 15,
  parameter int unsigned C_CNTWIDTH = 4,
  parameter int unsigned C_MARGIN   = 2,
  parameter int unsigned C_TIMEOUT  = 4096
) (
  input  logic        I_sclk,
  input  logic        I_rst_n,
  id_vote_if.slave    bus
);

  localparam int unsigned C_SMPW  = $clog2(C_VOTENUM + 1);
  localparam int unsigned C_TMOW  = $clog2(C_TIMEOUT + 1);
  localparam int unsigned C_UCNTW = ucnt_width(C_OIDWIDTH);

  if ((C_VOTENUM % 2 == 0) || (C_VOTENUM < 3) || (C_VOTENUM > 255)) begin : g_bad_votenum
    $error("id_vote: C_VOTENUM must be odd and within 3..255");
  end
  if ((2 ** C_CNTWIDTH) <= C_VOTENUM) begin : g_bad_cntwidth
    $error("id_vote: C_CNTWIDTH too narrow for C_VOTENUM");
  end
  if (C_MARGIN >= C_VOTENUM / 2) begin : g_bad_margin
    $error("id_vote: C_MARGIN must be below C_VOTENUM/2");
  end
  if (C_TIMEOUT < 1) begin : g_bad_timeout
    $error("id_vote: C_TIMEOUT must be at least 1");
  end

  vote_state_e           state_q, state_d;
  logic [C_SMPW-1:0]     smp_q, smp_d;
  logic [C_TMOW-1:0]     tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  cnt_clr, cnt_inc;
  logic [C_OIDWIDTH-1:0] maj, unst;
  logic [C_UCNTW-1:0]    pop;

  logic                  meas_req_q, busy_q, id_vld_q;
  logic [C_OIDWIDTH-1:0] id_q, mask_q;
  logic [C_UCNTW-1:0]    ucnt_q;

  for (genvar b = 0; b < C_OIDWIDTH; b++) begin : g_bit
    id_vote_bitcnt #(
      .C_VOTENUM (C_VOTENUM),
      .C_CNTWIDTH(C_CNTWIDTH),
      .C_MARGIN  (C_MARGIN)
    ) u_bitcnt (
      .I_sclk    (I_sclk),
      .I_rst_n   (I_rst_n),
      .I_clr     (cnt_clr),
      .I_inc     (cnt_inc & bus.I_prim_id[b]),
      .O_maj     (maj[b]),
      .O_unstable(unst[b])
    );
  end

  always_comb begin
    pop = '0;
    for (int unsigned b = 0; b < C_OIDWIDTH; b++) begin
      pop = pop + C_UCNTW'(unst[b]);
    end
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.I_start) begin
          cnt_clr = 1'b1;
          smp_d   = '0;
          err_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.I_prim_vld) begin
          cnt_inc = 1'b1;
          smp_d   = smp_q + 1'b1;
          state_d = (smp_q == C_SMPW'(C_VOTENUM - 1)) ? ST_EVAL : ST_REQ;
        end else if (tmo_q == C_TMOW'(C_TIMEOUT - 1)) begin
          // Partial counts are abandoned; they are cleared on the next start.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_EVAL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are flops
  // aligned with the state they describe.
  always_ff @(posedge I_sclk) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      smp_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      meas_req_q <= 1'b0;
      busy_q     <= 1'b0;
      id_vld_q   <= 1'b0;
      id_q       <= '0;
      mask_q     <= '0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      meas_req_q <= (state_d == ST_REQ);
      busy_q     <= (state_d != ST_IDLE);
      id_vld_q   <= (state_d == ST_DONE);
      if (state_q == ST_EVAL) begin
        id_q   <= maj;
        mask_q <= unst;
        ucnt_q <= pop;
      end
    end
  end

  assign bus.O_meas_req      = meas_req_q;
  assign bus.O_busy          = busy_q;
  assign bus.O_id_vld        = id_vld_q;
  assign bus.O_id            = id_q;
  assign bus.O_unstable_mask = mask_q;
  assign bus.O_unstable_cnt  = ucnt_q;
  assign bus.O_err           = err_q;

endmodule

// File: tb/tb_id_vote.sv
// tb_id_vote: directed bench for id_vote with a per-cycle expected-output
// model and a vote-result model computed from the supplied samples.
module tb_id_vote;

  localparam int W = 24;
  localparam int N = 15;
  localparam int M = 2;

  typedef logic [W-1:0] id_t;
  typedef id_t smp_arr_t [N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_vote_if #(.C_OIDWIDTH(W)) bus ();

  id_vote #(
    .C_OIDWIDTH(W),
    .C_VOTENUM (N),
    .C_CNTWIDTH(4),
    .C_MARGIN  (M),
    .C_TIMEOUT (4096)
  ) dut (
    .I_sclk (clk),
    .I_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int req_pulses = 0;

  logic       chk_en = 1'b0;
  logic       e_req, e_busy, e_vld, e_err;
  id_t        e_id, e_mask;
  logic [4:0] e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected vote result straight from the rules: count ones per bit.
  function automatic void vote_model(input smp_arr_t s, output id_t id,
                                     output id_t mask, output logic [4:0] ucnt);
    id   = '0;
    mask = '0;
    ucnt = '0;
    for (int b = 0; b < W; b++) begin
      int ones;
      ones = 0;
      for (int i = 0; i < N; i++) ones += int'(s[i][b]);
      id[b]   = (ones > N / 2);
      mask[b] = (ones > M) && (ones < N - M);
      ucnt    = ucnt + 5'(mask[b]);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.O_meas_req === 1'b1) req_pulses++;
      chk("meas_req", 32'(bus.O_meas_req), 32'(e_req));
      chk("busy", 32'(bus.O_busy), 32'(e_busy));
      chk("id_vld", 32'(bus.O_id_vld), 32'(e_vld));
      chk("err", 32'(bus.O_err), 32'(e_err));
      chk("id", 32'(bus.O_id), 32'(e_id));
      chk("mask", 32'(bus.O_unstable_mask), 32'(e_mask));
      chk("ucnt", 32'(bus.O_unstable_cnt), 32'(e_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call in an IDLE cycle; returns in the first REQ cycle.
  task automatic do_start();
    bus.I_start = 1'b1;
    req_pulses  = 0;
    step();
    bus.I_start = 1'b0;
    e_busy = 1'b1;
    e_req  = 1'b1;
    e_err  = 1'b0;
    e_vld  = 1'b0;
  endtask

  // Call in a REQ cycle; answers it after 'gap' idle WAIT cycles.
  task automatic feed(input id_t v, input int gap, input bit spur, input bit last);
    if (spur) begin
      bus.I_prim_vld = 1'b1;
      bus.I_prim_id  = '1;
    end
    step();
    bus.I_start    = 1'b0;
    bus.I_prim_vld = 1'b0;
    e_req = 1'b0;
    repeat (gap) step();
    bus.I_prim_vld = 1'b1;
    bus.I_prim_id  = v;
    step();
    bus.I_prim_vld = 1'b0;
    bus.I_prim_id  = id_t'($urandom);
    e_req = !last;
  endtask

  // Call in the EVAL cycle; returns in the IDLE cycle after DONE.
  task automatic finish(input smp_arr_t s, input bit start_in_done);
    step();
    vote_model(s, e_id, e_mask, e_cnt);
    e_vld = 1'b1;
    if (start_in_done) bus.I_start = 1'b1;
    step();
    bus.I_start = 1'b0;
    e_vld  = 1'b0;
    e_busy = 1'b0;
  endtask

  task automatic run_vote(input smp_arr_t s, input int gap_every);
    do_start();
    for (int i = 0; i < N; i++) begin
      feed(s[i], (gap_every > 0 && i % gap_every == 1) ? 2 : 0, 1'b0, i == N - 1);
    end
    finish(s, 1'b0);
    chk("req_count", 32'(req_pulses), 32'd15);
  endtask

  smp_arr_t s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.I_start    = 1'b0;
    bus.I_prim_vld = 1'b0;
    bus.I_prim_id  = '0;
    e_req = 1'b0; e_busy = 1'b0; e_vld = 1'b0; e_err = 1'b0;
    e_id = '0; e_mask = '0; e_cnt = '0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // Constant ID, with a few delayed answers.
    for (int i = 0; i < N; i++) s[i] = 24'hA5C3F0;
    run_vote(s, 4);
    chk("t1_id", 32'(bus.O_id), 32'h00A5C3F0);
    chk("t1_mask", 32'(bus.O_unstable_mask), 32'h0);
    chk("t1_cnt", 32'(bus.O_unstable_cnt), 32'd0);

    // Bit 0 alternating: 8 ones of 15, majority but unstable.
    for (int i = 0; i < N; i++) s[i] = (i % 2 == 0) ? 24'h000001 : 24'h000000;
    run_vote(s, 0);
    chk("t2_id", 32'(bus.O_id), 32'h000001);
    chk("t2_mask", 32'(bus.O_unstable_mask), 32'h000001);
    chk("t2_cnt", 32'(bus.O_unstable_cnt), 32'd1);

    // Bit 23 in 13 of 15: exactly at the stability edge.
    for (int i = 0; i < N; i++) s[i] = (i < 13) ? 24'h800000 : 24'h000000;
    run_vote(s, 0);
    chk("t3a_id", 32'(bus.O_id), 32'h800000);
    chk("t3a_mask", 32'(bus.O_unstable_mask), 32'h0);

    // Bit 23 in 12 of 15: just inside the unstable band.
    for (int i = 0; i < N; i++) s[i] = (i < 12) ? 24'h800000 : 24'h000000;
    run_vote(s, 3);
    chk("t3b_id", 32'(bus.O_id), 32'h800000);
    chk("t3b_mask", 32'(bus.O_unstable_mask), 32'h800000);
    chk("t3b_cnt", 32'(bus.O_unstable_cnt), 32'd1);

    // Timeout: third request left unanswered.
    do_start();
    feed(24'h0F0F0F, 0, 1'b0, 1'b0);
    feed(24'h0F0F0F, 0, 1'b0, 1'b0);
    step();
    e_req = 1'b0;
    for (int k = 1; k <= 4096; k++) begin
      step();
      if (k == 4096) begin
        e_err  = 1'b1;
        e_busy = 1'b0;
      end
    end
    chk("t4_err", 32'(bus.O_err), 32'd1);
    chk("t4_id_hold", 32'(bus.O_id), 32'h800000);
    chk("t4_req_count", 32'(req_pulses), 32'd3);
    step();

    // Reset after 7 samples, then a clean vote.
    do_start();
    for (int i = 0; i < 7; i++) feed(24'h123456, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    e_req = 1'b0; e_busy = 1'b0; e_vld = 1'b0; e_err = 1'b0;
    e_id = '0; e_mask = '0; e_cnt = '0;
    chk("t5_rst_id", 32'(bus.O_id), 32'h0);
    for (int i = 0; i < N; i++) s[i] = 24'h00FFFF;
    run_vote(s, 0);
    chk("t5_id", 32'(bus.O_id), 32'h00FFFF);

    // Mixed pattern, first clean then with ignored start/vld events.
    for (int i = 0; i < N; i++) s[i] = (i < 9) ? 24'h0F0F0F : 24'hF0F000;
    run_vote(s, 0);
    chk("t6c_id", 32'(bus.O_id), 32'h0F0F0F);
    chk("t6c_mask", 32'(bus.O_unstable_mask), 32'hFFFF0F);
    chk("t6c_cnt", 32'(bus.O_unstable_cnt), 32'd20);

    bus.I_prim_vld = 1'b1;
    bus.I_prim_id  = '1;
    step();
    bus.I_prim_vld = 1'b0;
    do_start();
    for (int i = 0; i < N; i++) begin
      if (i == 3) bus.I_start = 1'b1;
      feed(s[i], 0, (i == 0) || (i == 7), i == N - 1);
    end
    finish(s, 1'b1);
    step();
    chk("t6d_req_count", 32'(req_pulses), 32'd15);
    chk("t6d_id", 32'(bus.O_id), 32'h0F0F0F);
    chk("t6d_mask", 32'(bus.O_unstable_mask), 32'hFFFF0F);
    chk("t6d_cnt", 32'(bus.O_unstable_cnt), 32'd20);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
